// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared widths, address map and access-size encodings.
package data_mem_ctrl_pkg;
  localparam int ADDRESS_BUS_WIDTH = 10;
  localparam int DATA_BUS_WIDTH = 64;
  localparam int DATA_BASE = 512;
  localparam int NUM_DATA_ADDRESSES = 512;
  typedef logic [ADDRESS_BUS_WIDTH-1:0] addr_t;
  typedef logic [DATA_BUS_WIDTH-1:0] data_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;
  localparam addr_t BASE_ADDR = addr_t'(DATA_BASE);
  localparam addr_t MAX_OFF = addr_t'(NUM_DATA_ADDRESSES - 8);
  function automatic data_t size_mask(logic [1:0] size);
    return size == SZ_DOUBLE ? '1 : (data_t'(1) << (8 << size)) - data_t'(1);
  endfunction
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: CPU request/response and data_ram request pins of the load/store controller.
interface data_mem_ctrl_if;
  import data_mem_ctrl_pkg::*;
  logic cpu_req;
  logic cpu_we;
  logic [1:0] cpu_size;
  logic cpu_signed;
  addr_t cpu_addr;
  data_t cpu_wdata;
  logic cpu_busy;
  logic cpu_done;
  logic cpu_fault;
  data_t cpu_rdata;
  logic cs;
  logic memRead;
  logic memWrite;
  addr_t address;
  data_t writeData;
  data_t readData;
  modport slave (
    input cpu_req, cpu_we, cpu_size, cpu_signed, cpu_addr, cpu_wdata, readData,
    output cpu_busy, cpu_done, cpu_fault, cpu_rdata, cs, memRead, memWrite, address, writeData
  );
  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_signed, cpu_addr, cpu_wdata, readData,
    input cpu_busy, cpu_done, cpu_fault, cpu_rdata, cs, memRead, memWrite, address, writeData
  );
endinterface

// File: rtl/data_mem_ctrl_mem_align_unit.sv
// mem_align_unit: merges store bytes into a read doubleword and extracts/extends load data.
module mem_align_unit
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic       i_signed,
  input  data_t      i_raw,
  input  data_t      i_wdata,
  output data_t      o_merged,
  output data_t      o_load
);
  data_t w_mask;
  logic w_sign;
  assign w_mask = size_mask(i_size);
  assign w_sign = i_size == SZ_BYTE ? i_raw[7] :
                  i_size == SZ_HALF ? i_raw[15] :
                  i_size == SZ_WORD ? i_raw[31] : i_raw[63];
  assign o_merged = (i_raw & ~w_mask) | (i_wdata & w_mask);
  // for doubles the mask is all ones, so the extension term vanishes
  assign o_load = (i_raw & w_mask) | (i_signed && w_sign ? ~w_mask : '0);
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: one-at-a-time load/store controller in front of data_ram,
// with range/alignment checks and read-modify-write for sub-doubleword stores.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
(
  input logic clk,
  input logic reset_n,
  data_mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;
  state_t r_state;
  logic r_we, r_signed, r_busy, r_done, r_fault, r_cs, r_rd, r_wr;
  logic [1:0] r_size;
  addr_t r_addr;
  data_t r_wdata, r_wdat_out, r_rdata;
  addr_t w_off;
  logic w_mis, w_fault, w_dbl_st;
  data_t w_merged, w_load;
  assign w_off = bus.cpu_addr - BASE_ADDR;
  assign w_mis = |(bus.cpu_addr[2:0] & ~3'(3'b111 << bus.cpu_size));
  assign w_fault = bus.cpu_addr < BASE_ADDR || w_off > MAX_OFF || w_mis;
  assign w_dbl_st = bus.cpu_we && bus.cpu_size == SZ_DOUBLE;
  mem_align_unit u_align (
    .i_size(r_size), .i_signed(r_signed), .i_raw(bus.readData),
    .i_wdata(r_wdata), .o_merged(w_merged), .o_load(w_load)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      {r_we, r_signed, r_busy, r_done, r_fault, r_cs, r_rd, r_wr} <= '0;
      r_size <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_wdat_out <= '0;
      r_rdata <= '0;
    end else
      case (r_state)
        IDLE: if (bus.cpu_req) begin
          r_we <= bus.cpu_we;
          r_size <= bus.cpu_size;
          r_signed <= bus.cpu_signed;
          r_wdata <= bus.cpu_wdata;
          r_addr <= w_off;
          r_wdat_out <= bus.cpu_wdata;
          r_busy <= 1'b1;
          r_done <= w_fault;
          r_fault <= w_fault;
          r_cs <= !w_fault;
          r_rd <= !w_fault && !w_dbl_st;
          r_wr <= !w_fault && w_dbl_st;
          r_state <= w_fault ? DONE : w_dbl_st ? WR : RD;
        end
        RD: r_state <= RD_WAIT;
        // readData is valid here; stores go on to write back the merged doubleword
        RD_WAIT: begin
          r_state <= r_we ? WR : DONE;
          r_rd <= 1'b0;
          r_wr <= r_we;
          r_cs <= r_we;
          r_done <= !r_we;
          r_wdat_out <= w_merged;
          if (!r_we) r_rdata <= w_load;
        end
        WR: begin
          r_state <= DONE;
          r_cs <= 1'b0;
          r_wr <= 1'b0;
          r_done <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_done <= 1'b0;
          r_fault <= 1'b0;
          r_busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
  assign bus.cpu_busy = r_busy;
  assign bus.cpu_done = r_done;
  assign bus.cpu_fault = r_fault;
  assign bus.cpu_rdata = r_rdata;
  assign bus.cs = r_cs;
  assign bus.memRead = r_rd;
  assign bus.memWrite = r_wr;
  assign bus.address = r_addr;
  assign bus.writeData = r_wdat_out;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed plus randomized load/store traffic against a byte-array reference model.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] ram [NUM_DATA_ADDRESSES];
  logic [7:0] ref_mem [NUM_DATA_ADDRESSES];
  data_t ram_q;
  data_t exp_rdata = '0;
  always #5 clk = ~clk;
  data_mem_ctrl_if bus();
  data_mem_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  // behavioural data_ram: registered 8-byte read window, 8-byte write
  always @(posedge clk)
    if (bus.cs) begin
      if (bus.memWrite)
        for (int i = 0; i < 8; i++) ram[(int'(bus.address) + i) % NUM_DATA_ADDRESSES] <= bus.writeData[8*i +: 8];
      if (bus.memRead)
        for (int i = 0; i < 8; i++) ram_q[8*i +: 8] <= ram[(int'(bus.address) + i) % NUM_DATA_ADDRESSES];
    end
  assign bus.readData = bus.cs ? ram_q : '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn, input int addr, input data_t wdata);
    int off, n, lat, exp_lat, rd_cyc, wr_cyc;
    logic fault, cs_seen, both;
    int seen_addr;
    data_t v;
    @(negedge clk);
    chk("idle_busy", bus.cpu_busy, 0);
    bus.cpu_we = we;
    bus.cpu_size = size;
    bus.cpu_signed = sgn;
    bus.cpu_addr = addr_t'(addr);
    bus.cpu_wdata = wdata;
    bus.cpu_req = 1'b1;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    off = addr - DATA_BASE;
    n = 1 << size;
    fault = addr < DATA_BASE || off > NUM_DATA_ADDRESSES - 8 || addr % n != 0;
    exp_lat = fault ? 1 : !we ? 3 : size == SZ_DOUBLE ? 2 : 4;
    lat = 0; rd_cyc = 0; wr_cyc = 0; cs_seen = 0; both = 0; seen_addr = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.cs) begin cs_seen = 1; seen_addr = int'(bus.address); end
      if (bus.cs && bus.memRead) rd_cyc++;
      if (bus.cs && bus.memWrite) wr_cyc++;
      if (bus.memRead && bus.memWrite) both = 1;
      if (bus.cpu_done) break;
    end
    chk("latency", lat, exp_lat);
    chk("fault", bus.cpu_fault, fault);
    chk("cs_seen", cs_seen, !fault);
    chk("rw_excl", both, 0);
    if (!fault) begin
      chk("ram_addr", seen_addr, off);
      chk("rd_cycles", rd_cyc, (we && size == SZ_DOUBLE) ? 0 : 2);
      chk("wr_cycles", wr_cyc, we ? 1 : 0);
      if (we)
        for (int i = 0; i < n; i++) ref_mem[off + i] = wdata[8*i +: 8];
      else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[off + i];
        if (sgn && n < 8 && v[8*n-1])
          for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        exp_rdata = v;
      end
    end
    chk("rdata", bus.cpu_rdata, exp_rdata);
  endtask

  initial begin
    int diffs, first, second, cnt, sz, base, sub, a;
    for (int i = 0; i < NUM_DATA_ADDRESSES; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end
    ram[16] = 8'd20;
    ref_mem[16] = 8'd20;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_size = 0; bus.cpu_signed = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    #1;
    chk("rst_ctl", {bus.cpu_busy, bus.cpu_done, bus.cpu_fault, bus.cs, bus.memRead, bus.memWrite}, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_addr", bus.address, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_req(0, SZ_DOUBLE, 0, 528, '0);
    chk("ld528", bus.cpu_rdata, 64'd20);
    do_req(1, SZ_BYTE, 0, 544, 64'hFF);
    do_req(0, SZ_BYTE, 1, 544, '0);
    chk("ld_sbyte", bus.cpu_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(0, SZ_BYTE, 0, 544, '0);
    chk("ld_ubyte", bus.cpu_rdata, 64'hFF);
    do_req(1, SZ_DOUBLE, 0, 560, 64'h1122334455667788);
    do_req(1, SZ_HALF, 0, 560, 64'hBEEF);
    do_req(0, SZ_DOUBLE, 0, 560, '0);
    chk("half_rmw", bus.cpu_rdata, 64'h112233445566BEEF);
    do_req(0, SZ_WORD, 0, 530, '0);
    do_req(0, SZ_BYTE, 0, 100, '0);
    do_req(0, SZ_DOUBLE, 0, 1020, '0);
    chk("flt_rdata", bus.cpu_rdata, 64'h112233445566BEEF);
    // reset while the double store to 576 is in its write cycle
    @(negedge clk);
    bus.cpu_we = 1; bus.cpu_size = SZ_DOUBLE; bus.cpu_signed = 0; bus.cpu_addr = addr_t'(576);
    bus.cpu_wdata = 64'hDEAD_BEEF_CAFE_F00D; bus.cpu_req = 1;
    @(posedge clk);
    #1 bus.cpu_req = 0;
    @(negedge clk);
    chk("wr_active", bus.memWrite, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_memwrite", bus.memWrite, 0);
    chk("rst_mid_ctl", {bus.cpu_busy, bus.cpu_done, bus.cpu_fault, bus.cs, bus.memRead}, 0);
    chk("rst_mid_rdata", bus.cpu_rdata, 0);
    exp_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    diffs = 0;
    for (int i = 64; i < 72; i++) if (ram[i] !== ref_mem[i]) diffs++;
    chk("rst_no_write", diffs, 0);
    // back-to-back loads with cpu_req held high
    @(negedge clk);
    bus.cpu_we = 0; bus.cpu_size = SZ_DOUBLE; bus.cpu_addr = addr_t'(528); bus.cpu_req = 1;
    @(posedge clk);
    cnt = 0; first = 0; second = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.cpu_done) begin
        cnt++;
        if (cnt == 1) first = c; else second = c;
      end
      if (c == 8) bus.cpu_req = 0;
    end
    chk("b2b_count", cnt, 2);
    chk("b2b_gap", second - first, 4);
    chk("b2b_rdata", bus.cpu_rdata, 64'd20);
    exp_rdata = 64'd20;
    repeat (60) begin
      sz = $urandom_range(0, 3);
      base = $urandom_range(0, 63) * 8;
      sub = ($urandom_range(0, 7) >> sz) << sz;
      a = $urandom_range(0, 9) == 0 ? $urandom_range(0, 1023) : DATA_BASE + base + sub;
      do_req(1'($urandom_range(0, 1)), 2'(sz), 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end
    diffs = 0;
    for (int i = 0; i < NUM_DATA_ADDRESSES; i++) if (ram[i] !== ref_mem[i]) diffs++;
    chk("ram_image", diffs, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Load/store controller between the multicycle datapath and data_ram; sits directly upstream of data_ram and drives its clk-domain request pins (cs, memRead, memWrite, address, writeData).
Takes one CPU memory request at a time (byte/half/word/double, load or store) through a req/done handshake.
Performs range and alignment checks, translates CPU addresses into data_ram offsets and captures data_ram's registered read data.
Sign- or zero-extends loads; sub-doubleword stores use read-modify-write.

Parameters:
ADDRESS_BUS_WIDTH, 10, CPU and data_ram address width (bytes)
DATA_BUS_WIDTH, 64, data width
DATA_BASE, 512, first CPU byte address mapped to data_ram offset 0
NUM_DATA_ADDRESSES, 512, data_ram depth in bytes

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  request valid; sampled only in IDLE
cpu_we  in  1  1 = store, 0 = load
cpu_size  in  2  00 byte, 01 half, 10 word, 11 double
cpu_signed  in  1  load sign-extend enable
cpu_addr  in  ADDRESS_BUS_WIDTH  CPU byte address
cpu_wdata  in  DATA_BUS_WIDTH  store data, low-order bytes used
cpu_busy  out  1  high in every state except IDLE
cpu_done  out  1  one-cycle completion pulse
cpu_fault  out  1  valid with cpu_done; access rejected
cpu_rdata  out  DATA_BUS_WIDTH  load result, held until next done
cs  out  1  to data_ram chip select
memRead  out  1  to data_ram
memWrite  out  1  to data_ram
address  out  ADDRESS_BUS_WIDTH  data_ram byte offset
writeData  out  DATA_BUS_WIDTH  to data_ram
readData  in  DATA_BUS_WIDTH  from data_ram; registered, Z when cs low

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; request latches cleared. Reset mid-operation aborts at once. memWrite drops asynchronously, so no partial write is issued.
- Every RAM-side output is a register (Moore); memRead and memWrite are never both high.
- Accept: in IDLE with cpu_req=1, latch we/size/signed/addr/wdata at the rising edge. Compute off = cpu_addr - DATA_BASE.
- Fault if cpu_addr < DATA_BASE, or off > NUM_DATA_ADDRESSES-8 (data_ram always touches off..off+7), or cpu_addr is not a multiple of 2^cpu_size.
- Faulted requests: IDLE -> DONE; no cs; cpu_rdata unchanged.
- States: IDLE, RD, RD_WAIT, WR, DONE.
- RD: cs=1, memRead=1, address=off; data_ram registers bytes off..off+7 at the end of this cycle.
- RD_WAIT: keep cs=1, memRead=1, address=off, so readData stays driven (not Z). Capture readData at the end of this cycle.
- Load path: RD -> RD_WAIT -> DONE.
- Double store path: WR -> DONE.
- Sub-doubleword store path: RD -> RD_WAIT -> WR -> DONE.
- WR: cs=1, memWrite=1, address=off.
  - Double store: writeData = cpu_wdata.
  - Sub-doubleword store: writeData = captured data with its low 2^size bytes replaced by cpu_wdata's low bytes; upper bytes preserved.
- DONE: cpu_done=1 for exactly one cycle, cs=0; return to IDLE. A new request is accepted at the earliest on the next edge.
- Latency from accept edge to cpu_done high: load 3 cycles, double store 2, sub-doubleword store 4, fault 1.
- Load result: take the low 2^size bytes of the captured data. Zero-extend, or sign-extend from bit 8*2^size-1 when cpu_signed=1. Double ignores cpu_signed.
- cpu_rdata updates only on a successful load's DONE; stores and faults leave it unchanged.
- cpu_req is ignored while busy; it does not need to drop between requests.

Decomposition:
- Shared params include: ADDRESS_BUS_WIDTH, DATA_BUS_WIDTH, NUM_DATA_ADDRESSES, DATA_BASE, size encodings (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DOUBLE).
- State encoding stays local.
- One combinational sub-module, mem_align_unit: store byte-merge plus load extract/extend, taking size, signed, raw and wdata.

Test Plan:
- Load double at cpu_addr 528 (RAM holds 20 at off 16, zeros elsewhere) -> cs/memRead high for 2 cycles, address=16, cpu_done 3 cycles after accept, cpu_rdata=64'd20, fault=0.
- Store byte 0xFF at 544, then signed byte load at 544 -> RMW sequence RD,RD_WAIT,WR; off 32..39 = FF,00,...; load returns 64'hFFFF_FFFF_FFFF_FFFF; unsigned load returns 64'hFF.
- Store half 0xBEEF at 560 over a double 0x1122334455667788 -> read back double = 0x112233445566BEEF.
- Faults: word at 530 (misaligned), byte at 100 (below base), double at 1020 (off 508 > 504) -> done next cycle with fault=1, cs never asserted, cpu_rdata unchanged.
- reset_n pulled low during WR of a double store to 576 -> memWrite falls immediately, RAM off 64..71 unchanged, all outputs 0, IDLE.
- cpu_req held high across back-to-back loads -> second accepted on the edge after done; one done pulse per request.
